ofifo_drain: RTL and testbench

- Downstream stage of the corelet output FIFO.
- Pops completed psum vectors (col x psum_bw) from the OFIFO and writes them to the psum SRAM at consecutive addresses from a programmed base.
- Gives the top-level controller a start/busy/done handshake, so the controller does not have to sequence inst[6] and the SRAM CEN/WEN/address by hand.

---
 rtl/ofifo_drain_if.sv | 35 +++
 rtl/ofifo_drain.sv | 93 +++++++++
 tb/tb_ofifo_drain.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ofifo_drain_if.sv
// Handshake and data bundle between the controller/OFIFO/psum SRAM side and the
// ofifo_drain engine.
interface ofifo_drain_if #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 11
);
  logic                      start;
  logic [addr_bw-1:0]        base_addr;
  logic [len_bw-1:0]         len;
  logic                      hold;
  logic                      ofifo_o_valid;
  logic [psum_bw*col-1:0]    ofifo_o_out;
  logic                      ofifo_rd;
  logic                      sram_cen;
  logic                      sram_wen;
  logic [addr_bw-1:0]        sram_addr;
  logic [psum_bw*col-1:0]    sram_d;
  logic                      busy;
  logic                      done;
  logic [len_bw-1:0]         wr_count;

  // Environment side: controller, OFIFO and SRAM arbiter.
  modport master (
    output start, base_addr, len, hold, ofifo_o_valid, ofifo_o_out,
    input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done, wr_count
  );

  // Drain engine side.
  modport slave (
    input  start, base_addr, len, hold, ofifo_o_valid, ofifo_o_out,
    output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done, wr_count
  );
endinterface

// File: rtl/ofifo_drain.sv
// Drains completed psum vectors from the output FIFO into the psum SRAM at
// consecutive addresses, with a start/busy/done handshake for the controller.
module ofifo_drain #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 11
) (
  input logic         clk,
  input logic         reset,
  ofifo_drain_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t             state;
  logic [addr_bw-1:0] base_q;
  logic [len_bw-1:0]  len_q;
  logic [len_bw-1:0]  pops;
  logic               pop;

  // Pop is combinational so the OFIFO sees the strobe in the same cycle the
  // head vector is captured.
  assign pop          = (state == DRAIN) && bus.ofifo_o_valid && !bus.hold && (pops < len_q);
  assign bus.ofifo_rd = pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      pops          <= '0;
      bus.sram_cen  <= 1'b1;
      bus.sram_wen  <= 1'b1;
      bus.sram_addr <= '0;
      bus.sram_d    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.wr_count  <= '0;
    end else begin
      // A pop in this cycle becomes the SRAM write of the next cycle; the
      // address counts pops so it equals base + writes already completed.
      bus.sram_cen <= !pop;
      bus.sram_wen <= !pop;
      if (pop) begin
        bus.sram_d    <= bus.ofifo_o_out;
        bus.sram_addr <= base_q + addr_bw'(pops);
        pops          <= pops + len_bw'(1);
      end
      if (!bus.sram_cen) begin
        bus.wr_count <= bus.wr_count + len_bw'(1);
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            base_q       <= bus.base_addr;
            len_q        <= bus.len;
            pops         <= '0;
            bus.wr_count <= '0;
            if (bus.len == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state    <= DRAIN;
              bus.busy <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && (pops == len_q - len_bw'(1))) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          state    <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofifo_drain.sv
// Randomised scoreboard bench for ofifo_drain: a queue-based OFIFO/SRAM model
// predicts every pop, write, busy/done pulse and wr_count value.
module tb_ofifo_drain;

  localparam int W  = 128;
  localparam int AW = 11;
  localparam int LW = 11;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ofifo_drain_if bus ();

  ofifo_drain dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic [W-1:0] drv_fifo[$];
  logic [W-1:0] ref_fifo[$];
  wr_t          exp_wr[$];

  int checks        = 0;
  int failures      = 0;
  int cycle         = 0;
  int start_cycle   = 0;
  int cur_len       = 0;
  int pops_done     = 0;
  int writes_seen   = 0;
  int last_wr_cycle = 0;
  int wrc_model     = 0;
  int valid_pct     = 100;
  int hold_pct      = 0;
  bit model_busy    = 1'b0;
  bit pop_seen      = 1'b0;

  logic exp_rd, exp_done, exp_busy, active_drain, wr_now;
  wr_t  got_e;

  function automatic void checkOutput(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  // Monitor: compares every cycle against the queue-based reference model.
  always @(negedge clk) begin
    if (reset) begin
      active_drain = model_busy && (cur_len > 0) && (cycle > start_cycle) && (pops_done < cur_len);
      exp_rd       = active_drain && bus.ofifo_o_valid && !bus.hold;
      checkOutput("ofifo_rd", W'(bus.ofifo_rd), W'(exp_rd));
      if (exp_rd) pops_done++;

      wr_now = !bus.sram_cen;
      checkOutput("write_one_cycle_after_pop", W'(wr_now), W'(pop_seen));
      checkOutput("wr_count", W'(bus.wr_count), W'(wrc_model));
      if (wr_now) begin
        checkOutput("sram_wen_write", W'(bus.sram_wen), W'(0));
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_write: got addr %0h expected no write (cycle %0d)", bus.sram_addr, cycle);
        end else begin
          got_e = exp_wr.pop_front();
          checkOutput("sram_addr", W'(bus.sram_addr), W'(got_e.addr));
          checkOutput("sram_d", bus.sram_d, got_e.data);
        end
        writes_seen++;
        last_wr_cycle = cycle;
        wrc_model++;
      end else begin
        checkOutput("sram_wen_idle", W'(bus.sram_wen), W'(1));
      end

      exp_done = model_busy &&
                 (((cur_len == 0) && (cycle == start_cycle + 1)) ||
                  ((cur_len > 0) && (writes_seen == cur_len) && (cycle == last_wr_cycle + 1)));
      exp_busy = model_busy && (cycle > start_cycle) && !exp_done;
      checkOutput("done", W'(bus.done), W'(exp_done));
      checkOutput("busy", W'(bus.busy), W'(exp_busy));
      if (exp_done) begin
        checks++;
        if (exp_wr.size() != 0) begin
          failures++;
          $display("[TB] FAIL writes_before_done: got %0d pending expected 0", exp_wr.size());
        end
        model_busy = 1'b0;
      end
      if (model_busy && (cycle == start_cycle)) wrc_model = 0;
      pop_seen = bus.ofifo_rd;
    end else begin
      pop_seen = 1'b0;
    end
    cycle++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (pop_seen && (drv_fifo.size() > 0)) void'(drv_fifo.pop_front());
    bus.start         = 1'b0;
    bus.ofifo_o_valid = (drv_fifo.size() > 0) && ($urandom_range(0, 99) < valid_pct);
    bus.ofifo_o_out   = bus.ofifo_o_valid ? drv_fifo[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.hold          = ($urandom_range(0, 99) < hold_pct);
  endtask

  task automatic pushVecs(input int n);
    logic [W-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      drv_fifo.push_back(v);
      ref_fifo.push_back(v);
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkOutput("rst_ofifo_rd", W'(bus.ofifo_rd), W'(0));
    checkOutput("rst_sram_cen", W'(bus.sram_cen), W'(1));
    checkOutput("rst_sram_wen", W'(bus.sram_wen), W'(1));
    checkOutput("rst_sram_addr", W'(bus.sram_addr), W'(0));
    checkOutput("rst_sram_d", bus.sram_d, W'(0));
    checkOutput("rst_busy", W'(bus.busy), W'(0));
    checkOutput("rst_done", W'(bus.done), W'(0));
    checkOutput("rst_wr_count", W'(bus.wr_count), W'(0));
    drv_fifo.delete();
    ref_fifo.delete();
    exp_wr.delete();
    model_busy        = 1'b0;
    wrc_model         = 0;
    pop_seen          = 1'b0;
    bus.start         = 1'b0;
    bus.ofifo_o_valid = 1'b0;
    bus.hold          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Issues one start and lets the transfer run; optionally pulses a stray
  // start mid-transfer or aborts with reset after a number of writes.
  task automatic applyStimulus(input logic [AW-1:0] base, input logic [LW-1:0] len,
                               input int vpct, input int hpct,
                               input int ignore_at, input int abort_after);
    int  waited;
    wr_t e;
    valid_pct = vpct;
    hold_pct  = hpct;
    step();
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.len       = len;
    model_busy    = 1'b1;
    start_cycle   = cycle;
    cur_len       = int'(len);
    pops_done     = 0;
    writes_seen   = 0;
    for (int i = 0; i < int'(len); i++) begin
      e.addr = base + AW'(i);
      e.data = (ref_fifo.size() > 0) ? ref_fifo.pop_front() : W'(0);
      exp_wr.push_back(e);
    end
    waited = 0;
    while (model_busy && (waited < 300)) begin
      step();
      waited++;
      if (waited == ignore_at) begin
        bus.start     = 1'b1;
        bus.base_addr = ~base;
        bus.len       = LW'(7);
      end
      if ((abort_after > 0) && (writes_seen >= abort_after)) begin
        doReset();
        break;
      end
    end
    if (model_busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL transfer_timeout: got no done after %0d cycles expected done", waited);
      model_busy = 1'b0;
      exp_wr.delete();
    end
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.base_addr     = '0;
    bus.len           = '0;
    bus.hold          = 1'b0;
    bus.ofifo_o_valid = 1'b0;
    bus.ofifo_o_out   = '0;
    #2;
    doReset();

    pushVecs(4);
    applyStimulus(11'h010, 11'd4, 100, 0, 0, 0);
    pushVecs(3);
    applyStimulus(11'h100, 11'd3, 50, 25, 0, 0);
    applyStimulus(11'h200, 11'd0, 100, 0, 0, 0);
    pushVecs(4);
    applyStimulus(11'h7FE, 11'd4, 100, 0, 0, 0);

    pushVecs(6);
    applyStimulus(11'h020, 11'd2, 100, 0, 2, 0);
    repeat (3) step();
    applyStimulus(11'h030, 11'd2, 100, 0, 0, 0);
    applyStimulus(11'h040, 11'd2, 70, 10, 0, 0);

    pushVecs(5);
    applyStimulus(11'h050, 11'd5, 100, 0, 0, 2);
    pushVecs(1);
    applyStimulus(11'h060, 11'd1, 100, 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(0, 8);
      pushVecs(n + $urandom_range(0, 2));
      applyStimulus(AW'($urandom()), LW'(n), $urandom_range(40, 100), $urandom_range(0, 30), 0, 0);
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
